prco_fetch: RTL and testbench
=============================

# prco_fetch

Instruction fetch stage sitting directly upstream of the on-chip local memory and downstream-facing to the decoder. Owns the program counter and issues one-cycle fetch strobes with an address to local memory. Captures the returned word when memory signals decode-enable, then holds it for the decoder under a valid/ready handshake. Handles jump redirects, including flushing an in-flight fetch.

## Interface
- P_RESET_PC, 16'h0000, PC value loaded on reset
- P_HALT_WORD, 16'hFFFF, instruction word treated as halt (only with PRCO_FETCH_HALT_EN)

- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_en  in  1  run enable; new fetches are issued only while high
- i_mem_busy  in  1  memory port in use by the ALU stage; blocks fetch issue
- q_ce_fetch  out  1  one-cycle fetch strobe to local memory
- q_mem_addr  out  16  fetch address, valid while q_ce_fetch is high
- i_ce_dec  in  1  memory read-data-valid strobe
- i_mem_douta  in  16  memory read data
- q_instr  out  16  captured instruction word
- q_instr_pc  out  16  address the word was fetched from
- q_instr_valid  out  1  q_instr/q_instr_pc hold a valid instruction
- i_instr_ready  in  1  decoder accepts; transfer when valid && ready on an edge
- i_jmp_valid  in  1  redirect request, one cycle
- i_jmp_addr  in  16  redirect target
- q_pc  out  16  next fetch address
- q_halted  out  1  fetch halted

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT (S_HALT exists only with the macro).
- On reset: state S_IDLE; q_pc=P_RESET_PC; q_mem_addr=P_RESET_PC; q_ce_fetch=0; q_instr=0; q_instr_pc=0; q_instr_valid=0; q_halted=0; discard flag=0.
- S_IDLE -> S_REQ when i_en && !i_mem_busy.
- S_REQ: q_ce_fetch=1, q_mem_addr=q_pc for exactly one cycle. On the edge, latch the request address into q_instr_pc, set q_pc<=q_pc+1 (16-bit wrap: FFFF->0000), and go to S_WAIT.
- S_WAIT: on i_ce_dec, either capture i_mem_douta into q_instr and set q_instr_valid -> S_HOLD, or, if the discard flag is set, drop the word, clear the flag, and go to S_IDLE.
- S_HOLD: on valid && ready, clear q_instr_valid. Then go to S_REQ if i_en && !i_mem_busy, else S_IDLE.
- i_ce_dec outside S_WAIT is ignored.
- Jump (any state except S_HALT): q_pc<=i_jmp_addr.
  - In S_WAIT: set the discard flag.
  - In S_HOLD: clear q_instr_valid (flush). The held word is not transferred even if ready is high that cycle.
  - In S_REQ: the issued fetch is discarded (go to S_WAIT with the flag set). q_pc is the jump target, not the incremented value.
- Priorities: reset > jump > transfer > fetch issue.
- Deasserting i_en mid-fetch does not cancel it; the fetched word is still captured and presented.

## Timing
- Fetch latency:
  - Cycle 0: q_ce_fetch high.
  - Cycle 1: memory asserts i_ce_dec.
  - Cycle 2: q_instr_valid high.
- Throughput is one instruction per 3 cycles when the decoder is always ready.
- q_ce_fetch is never high in two consecutive cycles, and never high while i_mem_busy is high.
- A jump takes effect on the next issued fetch: earliest q_ce_fetch carrying i_jmp_addr is 1 cycle after the jump in S_IDLE/S_HOLD. In S_WAIT/S_REQ it comes after the discarded response returns.
- An asynchronous reset mid-S_WAIT abandons the fetch. A late i_ce_dec after reset is ignored (S_IDLE).

## Configuration
- PRCO_FETCH_HALT_EN defined: a captured word equal to P_HALT_WORD is presented normally.
  - After it transfers, the state goes to S_HALT with q_halted=1 and no further fetches.
  - Jumps are ignored in S_HALT; only reset exits.
- Not defined: no halt detection; q_halted tied 0; P_HALT_WORD unused.

## Test plan
- Reset, i_en=1, memory model with 1-cycle latency holding 24ab/23cd at 0/1, ready=1 -> q_ce_fetch at cycles 1 and 4 with addr 0000 and 0001; q_instr 24ab (pc 0000) then 23cd (pc 0001); q_pc=0002.
- Ready held low 5 cycles after first word -> q_instr_valid stays high, q_instr stable, no q_ce_fetch until the transfer.
- Jump to 00aa while in S_WAIT -> returned word is not presented; next q_ce_fetch addr=00aa; q_instr_pc=00aa.
- Jump plus ready in the same cycle in S_HOLD -> no transfer; valid low next cycle; next fetch addr = jump target.
- P_RESET_PC=FFFF -> first fetch at FFFF, second at 0000.
- i_mem_busy high 3 cycles -> no q_ce_fetch during that window.
- With PRCO_FETCH_HALT_EN: word FFFF fetched and transferred -> q_halted=1; no further fetches; jump ignored; reset clears q_halted.

Source files
------------

// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch stage between local memory and the decoder.
// Define PRCO_FETCH_HALT_EN to stop fetching after a P_HALT_WORD is consumed.
module prco_fetch #(
  parameter logic [15:0] P_RESET_PC  = 16'h0000,
  parameter logic [15:0] P_HALT_WORD = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_mem_busy,
  output logic        q_ce_fetch,
  output logic [15:0] q_mem_addr,
  input  logic        i_ce_dec,
  input  logic [15:0] i_mem_douta,
  output logic [15:0] q_instr,
  output logic [15:0] q_instr_pc,
  output logic        q_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_jmp_valid,
  input  logic [15:0] i_jmp_addr,
  output logic [15:0] q_pc,
  output logic        q_halted
);

`ifdef PRCO_FETCH_HALT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD
  } state_t;
`endif

  state_t      state, state_nx;
  logic [15:0] pc_nx;
  logic [15:0] instr_nx;
  logic [15:0] instr_pc_nx;
  logic        valid_nx;
  logic        discard, discard_nx;
  logic        go, jmp, issue;

  assign go    = i_en && !i_mem_busy;
  assign issue = (state == S_REQ) && !i_mem_busy;

  assign q_ce_fetch = issue;
  assign q_mem_addr = q_pc;

`ifdef PRCO_FETCH_HALT_EN
  assign jmp      = i_jmp_valid && (state != S_HALT);
  assign q_halted = (state == S_HALT);
`else
  wire unused_halt_word = ^P_HALT_WORD;
  assign jmp      = i_jmp_valid;
  assign q_halted = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    pc_nx       = q_pc;
    instr_nx    = q_instr;
    instr_pc_nx = q_instr_pc;
    valid_nx    = q_instr_valid;
    discard_nx  = discard;
    unique case (state)
      S_IDLE: begin
        if (go) state_nx = S_REQ;
      end
      S_REQ: begin
        // a busy memory port stalls the strobe in place
        if (issue) begin
          instr_pc_nx = q_pc;
          pc_nx       = q_pc + 16'd1;
          discard_nx  = jmp;
          state_nx    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_ce_dec) begin
          if (discard || jmp) begin
            discard_nx = 1'b0;
            state_nx   = S_IDLE;
          end else begin
            instr_nx = i_mem_douta;
            valid_nx = 1'b1;
            state_nx = S_HOLD;
          end
        end else if (jmp) begin
          discard_nx = 1'b1;
        end
      end
      S_HOLD: begin
        if (jmp) begin
          valid_nx = 1'b0;
          state_nx = go ? S_REQ : S_IDLE;
        end else if (i_instr_ready) begin
          valid_nx = 1'b0;
          state_nx = go ? S_REQ : S_IDLE;
`ifdef PRCO_FETCH_HALT_EN
          if (q_instr == P_HALT_WORD)
            state_nx = S_HALT;
`endif
        end
      end
`ifdef PRCO_FETCH_HALT_EN
      S_HALT: begin
        state_nx = S_HALT;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
    if (jmp) pc_nx = i_jmp_addr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      q_pc          <= P_RESET_PC;
      q_instr       <= 16'h0000;
      q_instr_pc    <= 16'h0000;
      q_instr_valid <= 1'b0;
      discard       <= 1'b0;
    end else begin
      state         <= state_nx;
      q_pc          <= pc_nx;
      q_instr       <= instr_nx;
      q_instr_pc    <= instr_pc_nx;
      q_instr_valid <= valid_nx;
      discard       <= discard_nx;
    end
  end

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch: directed stimulus with a transaction-level fetch model.
// Halt checks are compiled in when PRCO_FETCH_HALT_EN is defined.
module tb_prco_fetch;

`ifdef PRCO_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, busy = 1'b0, ready = 1'b0;
  logic        jv = 1'b0, inj = 1'b0, en2 = 1'b0;
  logic [15:0] ja = 16'h0000;

  logic        ce, v, halted;
  logic        dec = 1'b0;
  logic [15:0] addr, instr, ipc, pc;
  logic [15:0] douta = 16'h0000;

  logic        ce2, v2, h2;
  logic        dec2 = 1'b0;
  logic [15:0] addr2, instr2, ipc2, pc2;
  logic [15:0] douta2 = 16'h0000;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prco_fetch dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mem_busy(busy),
    .q_ce_fetch(ce), .q_mem_addr(addr),
    .i_ce_dec(dec), .i_mem_douta(douta),
    .q_instr(instr), .q_instr_pc(ipc), .q_instr_valid(v),
    .i_instr_ready(ready), .i_jmp_valid(jv), .i_jmp_addr(ja),
    .q_pc(pc), .q_halted(halted)
  );

  prco_fetch #(.P_RESET_PC(16'hFFFF)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_en(en2), .i_mem_busy(1'b0),
    .q_ce_fetch(ce2), .q_mem_addr(addr2),
    .i_ce_dec(dec2), .i_mem_douta(douta2),
    .q_instr(instr2), .q_instr_pc(ipc2), .q_instr_valid(v2),
    .i_instr_ready(1'b1), .i_jmp_valid(1'b0), .i_jmp_addr(16'h0000),
    .q_pc(pc2), .q_halted(h2)
  );

  function automatic logic [15:0] memw(input logic [15:0] a);
    if (a == 16'h0000) return 16'h24ab;
    if (a == 16'h0001) return 16'h23cd;
    return a ^ 16'h5a00;
  endfunction

  // one-cycle-latency local memory
  always @(posedge clk) begin
    dec    <= ce | inj;
    douta  <= memw(addr);
    dec2   <= ce2;
    douta2 <= memw(addr2);
  end

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // model: next fetch address, one outstanding fetch, one held word
  logic        m_valid = 1'b0, m_infl = 1'b0, m_drop = 1'b0;
  logic        m_halted = 1'b0;
  logic [15:0] m_next = 16'h0000, m_addr = 16'h0000;
  logic [15:0] m_instr = 16'h0000, m_ipc = 16'h0000;

  always @(posedge clk or posedge rst) begin : model
    logic        lv, li, ld, lh, j;
    logic [15:0] ln, la, lw, lp;
    if (rst) begin
      m_valid  <= 1'b0;
      m_infl   <= 1'b0;
      m_drop   <= 1'b0;
      m_halted <= 1'b0;
      m_next   <= 16'h0000;
    end else begin
      lv = m_valid; li = m_infl; ld = m_drop; lh = m_halted;
      ln = m_next;  la = m_addr; lw = m_instr; lp = m_ipc;
      j = jv && !m_halted;
      if (m_valid && j) begin
        lv = 1'b0;
      end else if (m_valid && ready) begin
        lv = 1'b0;
        if (HALT_EN && m_instr == 16'hFFFF) lh = 1'b1;
      end
      if (m_infl && dec) begin
        if (!m_drop && !j) begin
          lv = 1'b1; lw = memw(m_addr); lp = m_addr;
        end
        li = 1'b0;
      end
      if (ce) begin
        li = 1'b1; la = addr; ld = j; ln = addr + 16'd1;
      end else if (li && j) begin
        ld = 1'b1;
      end
      if (j) ln = ja;
      m_valid <= lv; m_infl <= li; m_drop <= ld; m_halted <= lh;
      m_next <= ln;  m_addr <= la; m_instr <= lw; m_ipc <= lp;
    end
  end

  logic prev_ce = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ce <= 1'b0;
    end else begin
      chk("m_valid", v, m_valid);
      if (m_valid) begin
        chk("m_instr", instr, m_instr);
        chk("m_ipc", ipc, m_ipc);
      end
      chk("m_pc", pc, m_next);
      chk("m_halted", halted, m_halted);
      if (ce) begin
        chk("m_fetch_addr", addr, m_next);
        chk("m_fetch_legal",
            16'(m_valid | m_infl | busy | prev_ce | m_halted), 16'h0);
      end
      prev_ce <= ce;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input int n);
    int k = 0;
    while (!ce && k < n) begin step(); k++; end
    chk("wait_ce", ce, 1);
  endtask

  task automatic wait_valid(input int n);
    int k = 0;
    while (!v && k < n) begin step(); k++; end
    chk("wait_valid", v, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", ce, 0);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_ipc", ipc, 16'h0000);
    chk("rst_valid", v, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst2_pc", pc2, 16'hFFFF);
    chk("rst2_addr", addr2, 16'hFFFF);

    // basic fetch: strobes at cycles 1 and 4
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    chk("c0_ce", ce, 0);
    step(); chk("c1_ce", ce, 1); chk("c1_addr", addr, 16'h0000);
    step(); chk("c2_ce", ce, 0);
    step();
    chk("c3_valid", v, 1); chk("c3_instr", instr, 16'h24ab);
    chk("c3_ipc", ipc, 16'h0000); chk("c3_pc", pc, 16'h0001);
    step(); chk("c4_ce", ce, 1); chk("c4_addr", addr, 16'h0001);
    en = 1'b0;
    step(); step();
    chk("c6_instr", instr, 16'h23cd); chk("c6_ipc", ipc, 16'h0001);
    chk("c6_pc", pc, 16'h0002);
    step(); chk("c7_valid", v, 0); chk("c7_ce", ce, 0);

    // decoder stall
    en = 1'b1; ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", v, 1);
      chk("stall_instr", instr, 16'h5a02);
      chk("stall_ce", ce, 0);
    end
    ready = 1'b1;
    step();
    chk("stall_rel_valid", v, 0);
    chk("stall_rel_ce", ce, 1);
    chk("stall_rel_addr", addr, 16'h0003);

    // jump during the request cycle
    jv = 1'b1; ja = 16'h0100;
    step(); jv = 1'b0;
    chk("jreq_pc", pc, 16'h0100);
    wait_ce(10); chk("jreq_addr", addr, 16'h0100);
    wait_valid(10);
    chk("jreq_ipc", ipc, 16'h0100); chk("jreq_instr", instr, 16'h5b00);

    // jump while waiting for the response
    wait_ce(10);
    step();
    jv = 1'b1; ja = 16'h00aa;
    step(); jv = 1'b0;
    chk("jwait_valid", v, 0);
    wait_ce(10); chk("jwait_addr", addr, 16'h00aa);
    wait_valid(10);
    chk("jwait_ipc", ipc, 16'h00aa); chk("jwait_instr", instr, 16'h5aaa);

    // jump and ready together while holding
    ready = 1'b0;
    step(); chk("jhold_pre", v, 1);
    jv = 1'b1; ja = 16'h0200; ready = 1'b1;
    step(); jv = 1'b0;
    chk("jhold_valid", v, 0);
    chk("jhold_ce", ce, 1);
    chk("jhold_addr", addr, 16'h0200);
    en = 1'b0;
    wait_valid(10);
    step();

    // memory busy window
    en = 1'b1; busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("busy_ce", ce, 0);
    end
    busy = 1'b0;
    step(); chk("busy_rel_ce", ce, 1); chk("busy_rel_addr", addr, 16'h0201);
    en = 1'b0;
    wait_valid(10);
    step();

    // reset while waiting, then a stray response
    en = 1'b1;
    wait_ce(10);
    step();
    rst = 1'b1;
    #1;
    chk("arst_valid", v, 0); chk("arst_pc", pc, 16'h0000);
    chk("arst_ce", ce, 0);
    step();
    rst = 1'b0; en = 1'b0; inj = 1'b1;
    step(); inj = 1'b0;
    step();
    chk("late_valid", v, 0); chk("late_ce", ce, 0);

    // reset PC at FFFF wraps
    en2 = 1'b1;
    step(); chk("w_c1_ce", ce2, 1); chk("w_c1_addr", addr2, 16'hFFFF);
    step(); step();
    chk("w_c3_valid", v2, 1); chk("w_c3_instr", instr2, 16'ha5ff);
    chk("w_c3_ipc", ipc2, 16'hFFFF); chk("w_c3_pc", pc2, 16'h0000);
    step(); chk("w_c4_ce", ce2, 1); chk("w_c4_addr", addr2, 16'h0000);
    en2 = 1'b0;
    repeat (3) step();

`ifdef PRCO_FETCH_HALT_EN
    en = 1'b1; jv = 1'b1; ja = 16'ha5ff;
    step(); jv = 1'b0;
    chk("h_addr", addr, 16'ha5ff);
    wait_valid(10);
    chk("h_instr", instr, 16'hFFFF);
    step();
    chk("h_halted", halted, 1);
    for (int i = 0; i < 4; i++) begin
      step(); chk("h_ce", ce, 0);
    end
    jv = 1'b1; ja = 16'h0300;
    step(); jv = 1'b0;
    chk("h_jmp_pc", pc, 16'ha600);
    rst = 1'b1;
    #1;
    chk("h_rst", halted, 0);
    step();
    rst = 1'b0; en = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
